// File: rtl/brownout_pkg.sv
// Shared types and constants for the brownout reset sequencer.
// The internal FSM keeps TRIP and HOLD apart; the external state port merges them.
package brownout_pkg;

  localparam int TRIM_W = 3;
  localparam logic [TRIM_W-1:0] TRIM_RST = 3'b111;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARM,
    ST_MON,
    ST_TRIP,
    ST_HOLD
  } state_t;

  typedef logic [1:0] state_code_t;

  function automatic state_code_t state_code(input state_t s);
    state_code_t c;
    case (s)
      ST_OFF:  c = 2'd0;
      ST_ARM:  c = 2'd1;
      ST_MON:  c = 2'd2;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/brownout_sync_deb.sv
// Multi-flop synchronizer for one asynchronous detector line, followed by an
// optional level debouncer (DEB_CYCLES = 0 passes the synchronized level through).
module brownout_sync_deb #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic async_in,
  output logic sync_out,
  output logic db_out
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      logic hold_unused;
      assign hold_unused = hold;
      assign db_out      = sync_out;
    end else begin : g_deb
      localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
      logic [CW-1:0] cnt_reg;
      logic          db_reg;

      // Any cycle where the input agrees with the accepted level restarts the run.
      always_ff @(posedge clk) begin
        if (rst || hold) begin
          cnt_reg <= '0;
          db_reg  <= 1'b0;
        end else if (sync_out != db_reg) begin
          if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
            db_reg  <= sync_out;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign db_out = db_reg;
    end
  endgenerate

endmodule

// File: rtl/brownout_reset_seq.sv
// Brownout sequencer: arms the analog detector, debounces its trip output and
// produces a stretched system reset, trip interrupt, event count and undervoltage flag.
module brownout_reset_seq
  import brownout_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 1024,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [TRIM_W-1:0] otrip_cfg,
  input  logic [TRIM_W-1:0] vtrip_cfg,
  input  logic              brout_in,
  input  logic              vunder_in,
  output logic              ena_out,
  output logic [TRIM_W-1:0] otrip,
  output logic [TRIM_W-1:0] vtrip,
  output logic              sys_rst,
  output logic              brout_irq,
  output logic              vunder_flag,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [1:0]        state
);

  localparam int TMR_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   tmr_reg, tmr_next;
  logic               new_trip;
  logic               brout_db, vunder_s;
  logic               deb_hold, mon_active;
  logic               brout_s_unused, vunder_db_unused;
  logic [TRIM_W-1:0]  otrip_reg, vtrip_reg;
  logic               irq_reg, vflag_reg;
  logic [CNT_W-1:0]   evt_reg;

  // The debouncer only runs once the detector has settled.
  assign deb_hold   = (state_reg == ST_OFF) || (state_reg == ST_ARM);
  assign mon_active = (state_reg == ST_MON) || (state_reg == ST_TRIP) || (state_reg == ST_HOLD);

  brownout_sync_deb #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_brout (
    .clk(clk), .rst(rst), .hold(deb_hold), .async_in(brout_in),
    .sync_out(brout_s_unused), .db_out(brout_db)
  );

  brownout_sync_deb #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(0)) u_vunder (
    .clk(clk), .rst(rst), .hold(deb_hold), .async_in(vunder_in),
    .sync_out(vunder_s), .db_out(vunder_db_unused)
  );

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg + TMR_W'(1);
    new_trip   = 1'b0;
    if (!en) begin
      state_next = ST_OFF;
      tmr_next   = '0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_ARM;
          tmr_next   = '0;
        end
        ST_ARM: begin
          if (tmr_reg == TMR_W'(SETTLE_CYCLES - 1)) begin
            state_next = ST_MON;
            tmr_next   = '0;
          end
        end
        ST_MON: begin
          tmr_next = '0;
          if (brout_db) begin
            state_next = ST_TRIP;
            new_trip   = 1'b1;
          end
        end
        ST_TRIP: begin
          tmr_next = '0;
          if (!brout_db) state_next = ST_HOLD;
        end
        ST_HOLD: begin
          // A relapse while stretching is the same event: no irq, no count.
          if (brout_db) begin
            state_next = ST_TRIP;
            tmr_next   = '0;
          end else if (tmr_reg == TMR_W'(HOLD_CYCLES - 1)) begin
            state_next = ST_MON;
            tmr_next   = '0;
          end
        end
        default: begin
          state_next = ST_OFF;
          tmr_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_OFF;
      tmr_reg   <= '0;
      otrip_reg <= TRIM_RST;
      vtrip_reg <= TRIM_RST;
      irq_reg   <= 1'b0;
      vflag_reg <= 1'b0;
      evt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      irq_reg   <= new_trip;
      if (state_reg == ST_OFF && en) begin
        otrip_reg <= otrip_cfg;
        vtrip_reg <= vtrip_cfg;
      end
      if (vunder_s && mon_active) begin
        vflag_reg <= 1'b1;
      end else if (clr) begin
        vflag_reg <= 1'b0;
      end
      if (new_trip) begin
        evt_reg <= clr ? CNT_W'(1) : ((&evt_reg) ? evt_reg : evt_reg + CNT_W'(1));
      end else if (clr) begin
        evt_reg <= '0;
      end
    end
  end

  assign ena_out     = (state_reg != ST_OFF);
  assign sys_rst     = (state_reg == ST_TRIP) || (state_reg == ST_HOLD);
  assign otrip       = otrip_reg;
  assign vtrip       = vtrip_reg;
  assign brout_irq   = irq_reg;
  assign vunder_flag = vflag_reg;
  assign evt_cnt     = evt_reg;
  assign state       = state_code(state_reg);

endmodule

// File: tb/tb_brownout_reset_seq.sv
// Bench for brownout_reset_seq: directed scenarios with literal timing checks,
// then randomized stimulus, all compared every cycle against a timestamp-based model.
module tb_brownout_reset_seq;

  localparam int SYNC   = 2;
  localparam int SETTLE = 8;
  localparam int DEB    = 4;
  localparam int HOLD   = 16;
  localparam int CW     = 4;
  localparam int P_OFF = 0, P_ARM = 1, P_MON = 2, P_TRIP = 3, P_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, brout_in = 1'b0, vunder_in = 1'b0;
  logic [2:0] otrip_cfg = 3'd0, vtrip_cfg = 3'd0;
  logic ena_out, sys_rst, brout_irq, vunder_flag;
  logic [2:0] otrip, vtrip;
  logic [CW-1:0] evt_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  brownout_reset_seq #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .DEB_CYCLES(DEB),
    .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .otrip_cfg(otrip_cfg), .vtrip_cfg(vtrip_cfg),
    .brout_in(brout_in), .vunder_in(vunder_in),
    .ena_out(ena_out), .otrip(otrip), .vtrip(vtrip), .sys_rst(sys_rst),
    .brout_irq(brout_irq), .vunder_flag(vunder_flag), .evt_cnt(evt_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases are tracked with entry timestamps; sync delay via a sample queue.
  int m_phase, m_since, cyc_n;
  bit m_db, m_irq, m_flag;
  int m_run, m_evt;
  logic [2:0] m_otrip, m_vtrip;
  bit bq[$], vq[$];

  always @(posedge clk) begin
    int old_phase;
    bit old_db, old_bs, old_vs, trip_now;
    cyc_n++;
    if (rst) begin
      m_phase = P_OFF; m_since = 0; m_db = 0; m_run = 0;
      m_irq = 0; m_flag = 0; m_evt = 0; m_otrip = 3'b111; m_vtrip = 3'b111;
      bq = {}; vq = {};
      for (int i = 0; i < SYNC; i++) begin bq.push_back(1'b0); vq.push_back(1'b0); end
    end else begin
      old_phase = m_phase; old_db = m_db; old_bs = bq[0]; old_vs = vq[0];
      trip_now = 0;
      if (old_vs && old_phase >= P_MON) m_flag = 1;
      else if (clr) m_flag = 0;
      if (!en) m_phase = P_OFF;
      else begin
        case (old_phase)
          P_OFF: begin m_phase = P_ARM; m_since = cyc_n; m_otrip = otrip_cfg; m_vtrip = vtrip_cfg; end
          P_ARM: if (cyc_n - m_since == SETTLE) m_phase = P_MON;
          P_MON: if (old_db) begin m_phase = P_TRIP; trip_now = 1; end
          P_TRIP: if (!old_db) begin m_phase = P_HOLD; m_since = cyc_n; end
          default: if (old_db) m_phase = P_TRIP;
                   else if (cyc_n - m_since == HOLD) m_phase = P_MON;
        endcase
      end
      m_irq = trip_now;
      if (trip_now) m_evt = clr ? 1 : ((m_evt == (1 << CW) - 1) ? m_evt : m_evt + 1);
      else if (clr) m_evt = 0;
      if (old_phase <= P_ARM) begin m_db = 0; m_run = 0; end
      else if (old_bs != old_db) begin
        m_run++;
        if (m_run == DEB) begin m_db = old_bs; m_run = 0; end
      end else m_run = 0;
      void'(bq.pop_front()); bq.push_back(brout_in);
      void'(vq.pop_front()); vq.push_back(vunder_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), (m_phase >= P_TRIP) ? 3 : m_phase);
      chk("ena_out", 32'(ena_out), 32'(m_phase != P_OFF));
      chk("sys_rst", 32'(sys_rst), 32'(m_phase >= P_TRIP));
      chk("brout_irq", 32'(brout_irq), 32'(m_irq));
      chk("vunder_flag", 32'(vunder_flag), 32'(m_flag));
      chk("evt_cnt", 32'(evt_cnt), m_evt);
      chk("otrip", 32'(otrip), 32'(m_otrip));
      chk("vtrip", 32'(vtrip), 32'(m_vtrip));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rst(input logic val, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sys_rst !== val && n < lim);
    if (sys_rst !== val) chk("wait_sys_rst_timeout", 32'(sys_rst), 32'(val));
  endtask

  task automatic do_trip();
    int n;
    brout_in = 1'b1;
    wait_rst(1'b1, 20, n);
    brout_in = 1'b0;
    wait_rst(1'b0, 40, n);
  endtask

  initial begin
    int n, brun;
    bit bval;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_otrip", 32'(otrip), 7);
    chk("rst_sys_rst", 32'(sys_rst), 0);
    chk("rst_evt", 32'(evt_cnt), 0);
    $display("step reset done");

    // Arm with detector output high during settle: must not trip.
    rst = 1'b0; en = 1'b1; otrip_cfg = 3'b010; vtrip_cfg = 3'b100; brout_in = 1'b1;
    cyc(1);
    chk("arm_ena", 32'(ena_out), 1);
    chk("arm_otrip", 32'(otrip), 3'b010);
    chk("arm_state", 32'(state), 1);
    cyc(3);
    brout_in = 1'b0;
    cyc(5);
    chk("mon_after_settle", 32'(state), 2);
    cyc(10);
    chk("no_trip_from_arm", 32'(sys_rst), 0);
    $display("step arm done");

    // Trip latency and release latency.
    brout_in = 1'b1;
    wait_rst(1'b1, 20, n);
    chk("trip_latency", n, SYNC + DEB + 1);
    chk("trip_irq", 32'(brout_irq), 1);
    chk("trip_evt", 32'(evt_cnt), 1);
    cyc(1);
    chk("irq_single", 32'(brout_irq), 0);
    brout_in = 1'b0;
    wait_rst(1'b0, 40, n);
    chk("release_latency", n, SYNC + DEB + 1 + HOLD);
    $display("step trip done");

    // Short glitches are rejected.
    repeat (3) begin
      brout_in = 1'b1; cyc(3);
      brout_in = 1'b0; cyc(6);
    end
    chk("glitch_no_trip", 32'(sys_rst), 0);
    chk("glitch_evt", 32'(evt_cnt), 1);
    $display("step glitch done");

    // Relapse during HOLD re-enters TRIP without counting.
    brout_in = 1'b1;
    wait_rst(1'b1, 20, n);
    brout_in = 1'b0;
    cyc(10);
    brout_in = 1'b1;
    cyc(6);
    brout_in = 1'b0;
    cyc(1);
    chk("retrip_sys_rst", 32'(sys_rst), 1);
    wait_rst(1'b0, 60, n);
    chk("retrip_evt", 32'(evt_cnt), 2);
    $display("step retrip done");

    // Counter saturation, then clr coinciding with a trip.
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_evt", 32'(evt_cnt), 0);
    repeat (17) do_trip();
    chk("evt_saturated", 32'(evt_cnt), 15);
    brout_in = 1'b1;
    cyc(SYNC + DEB);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_trip_rst", 32'(sys_rst), 1);
    chk("clr_trip_irq", 32'(brout_irq), 1);
    chk("clr_trip_evt", 32'(evt_cnt), 1);
    brout_in = 1'b0;
    wait_rst(1'b0, 40, n);
    $display("step saturation done");

    // Sticky undervoltage flag.
    vunder_in = 1'b1; cyc(3); vunder_in = 1'b0;
    cyc(2);
    chk("vflag_set", 32'(vunder_flag), 1);
    cyc(5);
    chk("vflag_sticky", 32'(vunder_flag), 1);
    vunder_in = 1'b1; cyc(3);
    clr = 1'b1; cyc(1); clr = 1'b0; vunder_in = 1'b0;
    chk("vflag_set_wins", 32'(vunder_flag), 1);
    cyc(4);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("vflag_cleared", 32'(vunder_flag), 0);
    $display("step vunder done");

    // en=0 during TRIP; cfg ignored outside OFF.
    brout_in = 1'b1;
    wait_rst(1'b1, 20, n);
    en = 1'b0; brout_in = 1'b0;
    cyc(1);
    chk("off_state", 32'(state), 0);
    chk("off_sys_rst", 32'(sys_rst), 0);
    chk("off_ena", 32'(ena_out), 0);
    en = 1'b1; otrip_cfg = 3'b101;
    cyc(10);
    otrip_cfg = 3'b001;
    cyc(3);
    chk("cfg_ignored_otrip", 32'(otrip), 3'b101);
    chk("cfg_ignored_state", 32'(state), 2);
    $display("step en_off done");

    // Reset in the middle of HOLD.
    brout_in = 1'b1;
    wait_rst(1'b1, 20, n);
    brout_in = 1'b0;
    cyc(12);
    rst = 1'b1; cyc(1); rst = 1'b0; en = 1'b0;
    chk("hold_rst_state", 32'(state), 0);
    chk("hold_rst_sys_rst", 32'(sys_rst), 0);
    chk("hold_rst_ena", 32'(ena_out), 0);
    chk("hold_rst_otrip", 32'(otrip), 7);
    chk("hold_rst_vtrip", 32'(vtrip), 7);
    chk("hold_rst_evt", 32'(evt_cnt), 0);
    $display("step rst_hold done");

    // Randomized run against the model.
    en = 1'b1; brun = 0; bval = 0;
    for (int i = 0; i < 4000; i++) begin
      if (brun == 0) begin
        brun = $urandom_range(1, 30);
        bval = 1'($urandom_range(0, 1));
      end
      brun--;
      brout_in  = bval;
      vunder_in = ($urandom_range(0, 19) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      otrip_cfg = 3'($urandom);
      vtrip_cfg = 3'($urandom);
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; clr = 1'b0; brout_in = 1'b0; vunder_in = 1'b0;
    cyc(2);
    $display("step random done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
